// File: rtl/pipeline_sequencer.sv
// Central sequencer for the 5-stage pipeline: global enable, debug run/step/halt,
// load-use stall, taken-branch flush, HALT drain and executed-cycle counting.
module pipeline_sequencer #(
    parameter int NB_REG       = 5,
    parameter int DRAIN_CYCLES = 3,
    parameter int NB_CYC_CNT   = 32
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_dbg_run,
    input  logic                  i_dbg_step,
    input  logic [NB_REG-1:0]     i_id_rs,
    input  logic [NB_REG-1:0]     i_id_rt,
    input  logic                  i_id_halt,
    input  logic [NB_REG-1:0]     i_ex_rt,
    input  logic                  i_ex_mem_read,
    input  logic                  i_ex_branch_taken,
    output logic                  o_pipe_en,
    output logic                  o_pc_write,
    output logic                  o_if_id_write,
    output logic                  o_id_bubble,
    output logic                  o_if_id_flush,
    output logic                  o_halted,
    output logic [NB_CYC_CNT-1:0] o_cycle_count
);

    // state   | meaning
    // IDLE    | pipeline frozen, waiting for run or step
    // RUN     | free-running execution with hazard handling
    // STEP    | single enabled cycle, then back to IDLE
    // DRAIN   | HALT seen; older instructions retiring, front end stalled
    // HALTED  | pipeline empty and frozen until reset
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_DRAIN,
        ST_HALTED
    } state_t;

    localparam int NB_DRAIN = (DRAIN_CYCLES > 2) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [NB_DRAIN-1:0] DRAIN_LOAD = NB_DRAIN'(DRAIN_CYCLES - 1);

    state_t              state;
    state_t              state_next;
    logic [NB_DRAIN-1:0] drain_cnt;
    logic                active;
    logic                load_use;
    logic                halt_det;

    assign active   = (state == ST_RUN) || (state == ST_STEP);
    assign load_use = i_ex_mem_read && (i_ex_rt != '0) &&
                      ((i_ex_rt == i_id_rs) || (i_ex_rt == i_id_rt));
    // A taken branch makes everything in IF/ID wrong-path, so it masks the lower-priority hazards.
    assign halt_det = active && !i_ex_branch_taken && !load_use && i_id_halt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state         <= ST_IDLE;
            drain_cnt     <= '0;
            o_halted      <= 1'b0;
            o_cycle_count <= '0;
        end else begin
            state <= state_next;
            if (halt_det)
                drain_cnt <= DRAIN_LOAD;
            else if ((state == ST_DRAIN) && (drain_cnt != '0))
                drain_cnt <= drain_cnt - 1'b1;
            if (state_next == ST_HALTED)
                o_halted <= 1'b1;
            if (o_pipe_en && (o_cycle_count != '1))
                o_cycle_count <= o_cycle_count + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (i_dbg_run)
                    state_next = ST_RUN;
                else if (i_dbg_step)
                    state_next = ST_STEP;
            end
            ST_RUN: begin
                if (halt_det)
                    state_next = ST_DRAIN;
                else if (!i_dbg_run)
                    state_next = ST_IDLE;
            end
            ST_STEP:   state_next = halt_det ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  if (drain_cnt == '0) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        o_pipe_en     = 1'b0;
        o_pc_write    = 1'b0;
        o_if_id_write = 1'b0;
        o_id_bubble   = 1'b0;
        o_if_id_flush = 1'b0;
        if (active) begin
            o_pipe_en = 1'b1;
            if (i_ex_branch_taken) begin
                o_pc_write    = 1'b1;
                o_if_id_write = 1'b1;
                o_id_bubble   = 1'b1;
                o_if_id_flush = 1'b1;
            end else if (load_use || i_id_halt) begin
                o_id_bubble = 1'b1;
            end else begin
                o_pc_write    = 1'b1;
                o_if_id_write = 1'b1;
            end
        end else if (state == ST_DRAIN) begin
            o_pipe_en   = 1'b1;
            o_id_bubble = 1'b1;
        end
    end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer: stimulus pushes per-cycle expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pipeline_sequencer;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        i_dbg_run;
    logic        i_dbg_step;
    logic [4:0]  i_id_rs;
    logic [4:0]  i_id_rt;
    logic        i_id_halt;
    logic [4:0]  i_ex_rt;
    logic        i_ex_mem_read;
    logic        i_ex_branch_taken;
    logic        o_pipe_en;
    logic        o_pc_write;
    logic        o_if_id_write;
    logic        o_id_bubble;
    logic        o_if_id_flush;
    logic        o_halted;
    logic [31:0] o_cycle_count;

    pipeline_sequencer dut (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_dbg_run         (i_dbg_run),
        .i_dbg_step        (i_dbg_step),
        .i_id_rs           (i_id_rs),
        .i_id_rt           (i_id_rt),
        .i_id_halt         (i_id_halt),
        .i_ex_rt           (i_ex_rt),
        .i_ex_mem_read     (i_ex_mem_read),
        .i_ex_branch_taken (i_ex_branch_taken),
        .o_pipe_en         (o_pipe_en),
        .o_pc_write        (o_pc_write),
        .o_if_id_write     (o_if_id_write),
        .o_id_bubble       (o_id_bubble),
        .o_if_id_flush     (o_if_id_flush),
        .o_halted          (o_halted),
        .o_cycle_count     (o_cycle_count)
    );

    always #5 i_clock = ~i_clock;

    // expected vector order: {pipe_en, pc_write, if_id_write, id_bubble, if_id_flush, halted}
    localparam logic [5:0] E_OFF   = 6'b000000;
    localparam logic [5:0] E_RUN   = 6'b111000;
    localparam logic [5:0] E_STALL = 6'b100100;
    localparam logic [5:0] E_FLUSH = 6'b111110;
    localparam logic [5:0] E_HALT  = 6'b000001;

    string       q_name[$];
    logic [5:0]  q_vec[$];
    int unsigned q_cnt[$];
    int unsigned exp_cnt = 0;
    int          checks  = 0;
    int          passed  = 0;

    // Drives one cycle of inputs just after the rising edge and queues what that cycle must show.
    task automatic cyc(input string nm, input logic rst, input logic run, input logic step,
                       input logic [4:0] rs, input logic [4:0] rt, input logic halt,
                       input logic [4:0] ex_rt, input logic mr, input logic bt,
                       input logic [5:0] exp_vec);
        @(posedge i_clock);
        #1;
        i_reset           = rst;
        i_dbg_run         = run;
        i_dbg_step        = step;
        i_id_rs           = rs;
        i_id_rt           = rt;
        i_id_halt         = halt;
        i_ex_rt           = ex_rt;
        i_ex_mem_read     = mr;
        i_ex_branch_taken = bt;
        if (!rst) exp_cnt = 0;
        q_name.push_back(nm);
        q_vec.push_back(exp_vec);
        q_cnt.push_back(exp_cnt);
        if (exp_vec[5]) exp_cnt++;
    endtask

    task automatic idle(input string nm, input logic run, input logic step, input logic [5:0] e);
        cyc(nm, 1'b1, run, step, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, e);
    endtask

    always @(negedge i_clock) begin
        if (q_vec.size() > 0) begin
            string       nm;
            logic [5:0]  ev;
            logic [5:0]  got;
            int unsigned ec;
            nm  = q_name.pop_front();
            ev  = q_vec.pop_front();
            ec  = q_cnt.pop_front();
            got = {o_pipe_en, o_pc_write, o_if_id_write, o_id_bubble, o_if_id_flush, o_halted};
            checks++;
            if (got === ev && o_cycle_count === ec)
                passed++;
            else
                $display("FAIL %s: outputs=%b count=%0d, required outputs=%b count=%0d",
                         nm, got, o_cycle_count, ev, ec);
        end
    end

    initial begin
        i_reset = 1'b0; i_dbg_run = 1'b1; i_dbg_step = 1'b0;
        i_id_rs = '0; i_id_rt = '0; i_id_halt = 1'b0;
        i_ex_rt = '0; i_ex_mem_read = 1'b0; i_ex_branch_taken = 1'b0;

        // T1 reset held with run requested
        cyc("reset_run", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_OFF);
        cyc("reset_run2", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_OFF);
        idle("release", 1'b0, 1'b0, E_OFF);

        // T2 three step pulses spaced four cycles; third one also pokes step during STEP
        for (int p = 0; p < 3; p++) begin
            idle("step_req", 1'b0, 1'b1, E_OFF);
            idle("step_exec", 1'b0, (p == 2), E_RUN);
            idle("step_after", 1'b0, 1'b0, E_OFF);
            idle("step_gap", 1'b0, 1'b0, E_OFF);
        end

        // T3 load-use in RUN
        idle("run_req", 1'b1, 1'b0, E_OFF);
        idle("run_plain", 1'b1, 1'b0, E_RUN);
        cyc("lu_rs",     1'b1, 1'b1, 1'b0, 5'd5, 5'd1, 1'b0, 5'd5, 1'b1, 1'b0, E_STALL);
        cyc("lu_r0",     1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0, E_RUN);
        cyc("lu_rt",     1'b1, 1'b1, 1'b0, 5'd2, 5'd7, 1'b0, 5'd7, 1'b1, 1'b0, E_STALL);
        cyc("lu_nomatch",1'b1, 1'b1, 1'b0, 5'd6, 5'd5, 1'b0, 5'd7, 1'b1, 1'b0, E_RUN);
        cyc("lu_nomr",   1'b1, 1'b1, 1'b0, 5'd5, 5'd5, 1'b0, 5'd5, 1'b0, 1'b0, E_RUN);
        idle("run_step_ign", 1'b1, 1'b1, E_RUN);
        // T4 branch beats load-use
        cyc("br_vs_lu",  1'b1, 1'b1, 1'b0, 5'd5, 5'd0, 1'b0, 5'd5, 1'b1, 1'b1, E_FLUSH);
        // T6 branch masks HALT; sequencer stays in RUN
        cyc("br_vs_halt",1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, E_FLUSH);
        idle("still_run", 1'b1, 1'b0, E_RUN);
        idle("run_drop", 1'b0, 1'b0, E_RUN);
        idle("back_idle", 1'b0, 1'b0, E_OFF);

        // load-use during a single step
        idle("step2_req", 1'b0, 1'b1, E_OFF);
        cyc("step_lu",   1'b1, 1'b0, 1'b0, 5'd1, 5'd3, 1'b0, 5'd3, 1'b1, 1'b0, E_STALL);
        idle("step2_after", 1'b0, 1'b0, E_OFF);

        // T5 halt in RUN: detect, three drain cycles, then sticky halted
        idle("run2_req", 1'b1, 1'b0, E_OFF);
        idle("run2", 1'b1, 1'b0, E_RUN);
        cyc("halt_det",  1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, E_STALL);
        idle("drain1", 1'b0, 1'b0, E_STALL);
        idle("drain2", 1'b1, 1'b1, E_STALL);
        idle("drain3", 1'b0, 1'b1, E_STALL);
        idle("halted1", 1'b1, 1'b0, E_HALT);
        idle("halted2", 1'b0, 1'b1, E_HALT);
        idle("halted3", 1'b1, 1'b0, E_HALT);

        // reset from HALTED, then halt reached through STEP
        cyc("reset2", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_OFF);
        idle("release2", 1'b0, 1'b0, E_OFF);
        idle("step3_req", 1'b0, 1'b1, E_OFF);
        cyc("step_halt", 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, E_STALL);
        idle("sdrain1", 1'b0, 1'b0, E_STALL);
        idle("sdrain2", 1'b0, 1'b0, E_STALL);
        idle("sdrain3", 1'b0, 1'b0, E_STALL);
        idle("shalted", 1'b0, 1'b0, E_HALT);

        // reset in the middle of DRAIN aborts to IDLE
        cyc("reset3", 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_OFF);
        idle("release3", 1'b0, 1'b0, E_OFF);
        idle("run3_req", 1'b1, 1'b0, E_OFF);
        cyc("halt_det3", 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, E_STALL);
        idle("mdrain1", 1'b1, 1'b0, E_STALL);
        cyc("reset_drain", 1'b0, 1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_OFF);
        idle("release4", 1'b0, 1'b0, E_OFF);
        idle("idle_final", 1'b0, 1'b0, E_OFF);

        for (int w = 0; w < 20 && q_vec.size() > 0; w++) @(posedge i_clock);
        if (q_vec.size() > 0) begin
            checks++;
            $display("FAIL drain_queue: %0d entries left, required 0", q_vec.size());
        end
        @(posedge i_clock);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time %0t exceeded, required completion", $time);
        $display("%0d/%0d checks passed", passed, checks + 1);
        $fatal(1);
    end

endmodule
